// File: rtl/lcd_instr_engine.sv
// HD44780-style write engine: moves one instruction/data byte onto the LCD pins in
// 4-bit (two nibbles) or 8-bit bus mode, with cycle-programmable setup/strobe/hold/exec timing.
module lcd_instr_engine #(
    parameter int BUS_MODE    = 4,
    parameter int T_AS        = 2,
    parameter int T_EPW       = 12,
    parameter int T_H         = 1,
    parameter int T_NIB       = 50,
    parameter int T_EXEC      = 2000,
    parameter int T_EXEC_LONG = 82000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [9:0] data,
    input  logic       nibble_only,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [7:0] lcd_db
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int T_MAX = max2(max2(max2(T_EXEC_LONG, T_EXEC), max2(T_NIB, T_EPW)),
                                max2(T_AS, T_H));
    localparam int CNT_W = $clog2(T_MAX + 1);
    localparam bit FOUR_BIT = (BUS_MODE != 8);

    localparam logic [CNT_W-1:0] LD_AS   = CNT_W'(T_AS - 1);
    localparam logic [CNT_W-1:0] LD_EPW  = CNT_W'(T_EPW - 1);
    localparam logic [CNT_W-1:0] LD_H    = CNT_W'(T_H - 1);
    localparam logic [CNT_W-1:0] LD_NIB  = CNT_W'(T_NIB - 1);
    localparam logic [CNT_W-1:0] LD_EX   = CNT_W'(T_EXEC - 1);
    localparam logic [CNT_W-1:0] LD_EXL  = CNT_W'(T_EXEC_LONG - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_E_HIGH,
        S_HOLD,
        S_GAP,
        S_EXEC_WAIT
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       byte_q;
    logic             nib_only_q;
    logic             lower_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic             lcd_e_q;
    logic             lcd_rs_q;
    logic [7:0]       lcd_db_q;
    logic             long_wait;
    logic             cnt_zero;

    // Bus image for the selected nibble; 4-bit mode drives only [7:4].
    function automatic logic [7:0] bus_value(input logic [7:0] b, input logic lower);
        if (!FOUR_BIT)
            return b;
        else if (lower)
            return {b[3:0], 4'h0};
        else
            return {b[7:4], 4'h0};
    endfunction

    // Clear display (0x01) and return home (0x02/0x03) need the long execution time.
    assign long_wait = !lcd_rs_q && (byte_q inside {8'h01, 8'h02, 8'h03});
    assign cnt_zero  = (cnt_q == '0);

    // NOTE: all state and outputs live in one clocked block with non-blocking
    // assignments, so every output is a flop and reads of *_q see last-cycle values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            byte_q     <= '0;
            nib_only_q <= 1'b0;
            lower_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            lcd_e_q    <= 1'b0;
            lcd_rs_q   <= 1'b0;
            lcd_db_q   <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (data[8]) begin
                            err_q <= 1'b1;
                        end else begin
                            byte_q     <= data[7:0];
                            nib_only_q <= nibble_only && FOUR_BIT;
                            lower_q    <= 1'b0;
                            busy_q     <= 1'b1;
                            lcd_rs_q   <= data[9];
                            lcd_db_q   <= bus_value(data[7:0], 1'b0);
                            cnt_q      <= LD_AS;
                            state_q    <= S_SETUP;
                        end
                    end
                end
                S_SETUP: begin
                    if (cnt_zero) begin
                        lcd_e_q <= 1'b1;
                        cnt_q   <= LD_EPW;
                        state_q <= S_E_HIGH;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_E_HIGH: begin
                    if (cnt_zero) begin
                        lcd_e_q <= 1'b0;
                        cnt_q   <= LD_H;
                        state_q <= S_HOLD;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_HOLD: begin
                    if (cnt_zero) begin
                        if (FOUR_BIT && !lower_q && !nib_only_q) begin
                            cnt_q   <= LD_NIB;
                            state_q <= S_GAP;
                        end else begin
                            cnt_q   <= long_wait ? LD_EXL : LD_EX;
                            state_q <= S_EXEC_WAIT;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_GAP: begin
                    if (cnt_zero) begin
                        lower_q  <= 1'b1;
                        lcd_db_q <= bus_value(byte_q, 1'b1);
                        cnt_q    <= LD_AS;
                        state_q  <= S_SETUP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_EXEC_WAIT: begin
                    if (cnt_zero) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    lcd_e_q <= 1'b0;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;
    assign lcd_e  = lcd_e_q;
    assign lcd_rs = lcd_rs_q;
    assign lcd_rw = 1'b0;
    assign lcd_db = lcd_db_q;

endmodule

// File: tb/tb_lcd_instr_engine.sv
// Directed bench for lcd_instr_engine: a 4-bit and an 8-bit instance share clock and reset;
// a vector table drives complete transfers, hand sequences cover reject/reset/back-to-back.
module tb_lcd_instr_engine;

    localparam int LONG = 8200;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_r;
    logic       sel8;
    logic       nib;
    logic [9:0] data;
    logic       start4, start8;

    logic       busy4, done4, err4, e4, rs4, rw4;
    logic [7:0] db4;
    logic       busy8, done8, err8, e8, rs8, rw8;
    logic [7:0] db8;

    logic       m_busy, m_done, m_err, m_e, m_rs;
    logic [7:0] m_db;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign start4 = start_r & ~sel8;
    assign start8 = start_r & sel8;

    lcd_instr_engine #(.BUS_MODE(4), .T_EXEC_LONG(LONG)) u_dut4 (
        .clk(clk), .reset(reset), .start(start4), .data(data), .nibble_only(nib),
        .busy(busy4), .done(done4), .err(err4), .lcd_e(e4), .lcd_rs(rs4),
        .lcd_rw(rw4), .lcd_db(db4)
    );

    lcd_instr_engine #(.BUS_MODE(8), .T_EXEC_LONG(LONG)) u_dut8 (
        .clk(clk), .reset(reset), .start(start8), .data(data), .nibble_only(nib),
        .busy(busy8), .done(done8), .err(err8), .lcd_e(e8), .lcd_rs(rs8),
        .lcd_rw(rw8), .lcd_db(db8)
    );

    always_comb begin
        m_busy = sel8 ? busy8 : busy4;
        m_done = sel8 ? done8 : done4;
        m_err  = sel8 ? err8  : err4;
        m_e    = sel8 ? e8    : e4;
        m_rs   = sel8 ? rs8   : rs4;
        m_db   = sel8 ? db8   : db4;
    end

    typedef struct {
        logic       is8;
        logic [9:0] data;
        logic       nib;
        int         pulses;
        logic [7:0] db0;
        logic [7:0] db1;
        logic       rs;
        int         done_cyc;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Runs one accepted transfer; cycle 0 is the first negedge after the accepting edge.
    task automatic run_transfer(input vec_t v, input string tag);
        int         pulses = 0, rise0 = -1, len0 = 0, rise1 = -1;
        int         bad_rs = 0, bad_busy = 0, errs = 0, lown = 0, done_cyc = -1;
        logic [7:0] db0 = 8'hxx, db1 = 8'hxx;
        logic       prev_e = 1'b0;
        logic       busy_at_done = 1'b1;
        sel8    = v.is8;
        data    = v.data;
        nib     = v.nib;
        start_r = 1'b1;
        @(negedge clk);
        start_r = 1'b0;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            if (m_done) begin
                done_cyc     = cyc;
                busy_at_done = m_busy;
                break;
            end
            if (m_err) errs++;
            if (!m_busy) bad_busy++;
            if (m_rs !== v.rs) bad_rs++;
            if (!v.is8 && m_db[3:0] !== 4'h0) lown++;
            if (m_e && !prev_e) begin
                if (pulses == 0) begin
                    rise0 = cyc;
                    db0   = m_db;
                end else if (pulses == 1) begin
                    rise1 = cyc;
                    db1   = m_db;
                end
                pulses++;
            end
            if (m_e && pulses == 1) len0++;
            prev_e = m_e;
            // Read requests while busy must be ignored, not rejected.
            if (cyc == 30 || cyc == v.done_cyc - 10) begin
                start_r = 1'b1;
                data    = 10'h1A5;
            end else begin
                start_r = 1'b0;
            end
            @(negedge clk);
        end
        start_r = 1'b0;
        check({tag, " done_cycle"}, done_cyc, v.done_cyc);
        check({tag, " busy_at_done"}, {31'd0, busy_at_done}, 0);
        check({tag, " e_pulses"}, pulses, v.pulses);
        check({tag, " db_first"}, {24'd0, db0}, {24'd0, v.db0});
        check({tag, " e_rise_first"}, rise0, 2);
        check({tag, " e_width_first"}, len0, 12);
        if (v.pulses == 2) begin
            check({tag, " db_second"}, {24'd0, db1}, {24'd0, v.db1});
            check({tag, " e_rise_second"}, rise1, 67);
        end
        check({tag, " rs_bad_cycles"}, bad_rs, 0);
        check({tag, " busy_low_cycles"}, bad_busy, 0);
        check({tag, " err_while_busy"}, errs, 0);
        check({tag, " low_nibble_nonzero"}, lown, 0);
    endtask

    initial begin
        int late_done;
        vecs[0] = '{1'b0, 10'h028, 1'b0, 2, 8'h20, 8'h80, 1'b0, 2080};
        vecs[1] = '{1'b0, 10'h241, 1'b0, 2, 8'h40, 8'h10, 1'b1, 2080};
        vecs[2] = '{1'b0, 10'h001, 1'b0, 2, 8'h00, 8'h10, 1'b0, 30 + 50 + LONG};
        vecs[3] = '{1'b0, 10'h030, 1'b1, 1, 8'h30, 8'h00, 1'b0, 2015};
        vecs[4] = '{1'b1, 10'h038, 1'b0, 1, 8'h38, 8'h00, 1'b0, 2015};
        vecs[5] = '{1'b1, 10'h241, 1'b1, 1, 8'h41, 8'h00, 1'b1, 2015};
        vecs[6] = '{1'b0, 10'h201, 1'b0, 2, 8'h00, 8'h10, 1'b1, 2080};
        vecs[7] = '{1'b1, 10'h003, 1'b0, 1, 8'h03, 8'h00, 1'b0, 15 + LONG};
        vecs[8] = '{1'b0, 10'h002, 1'b1, 1, 8'h00, 8'h00, 1'b0, 15 + LONG};

        reset   = 1'b1;
        start_r = 1'b0;
        sel8    = 1'b0;
        nib     = 1'b0;
        data    = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs_4bit", {20'd0, busy4, done4, err4, e4, rs4, rw4, db4}, 0);
        check("reset_outputs_8bit", {20'd0, busy8, done8, err8, e8, rs8, rw8, db8}, 0);
        reset = 1'b0;
        @(negedge clk);

        run_transfer(vecs[0], "v0");

        // Read request: one err pulse, bus keeps 0x80 from the previous lower nibble.
        sel8    = 1'b0;
        data    = 10'h1A5;
        start_r = 1'b1;
        @(negedge clk);
        start_r = 1'b0;
        check("reject_err_pulse", {31'd0, err4}, 1);
        check("reject_busy", {31'd0, busy4}, 0);
        check("reject_e", {31'd0, e4}, 0);
        check("reject_db_held", {24'd0, db4}, 32'h80);
        @(negedge clk);
        check("reject_err_one_cycle", {30'd0, err4, busy4}, 0);

        for (int i = 1; i < 9; i++) run_transfer(vecs[i], $sformatf("v%0d", i));

        // Reset during E_HIGH of the lower nibble (cycles 67..78).
        sel8    = 1'b0;
        nib     = 1'b0;
        data    = 10'h028;
        start_r = 1'b1;
        @(negedge clk);
        start_r = 1'b0;
        repeat (70) @(negedge clk);
        check("pre_reset_e_high", {23'd0, e4, db4}, {23'd0, 1'b1, 8'h80});
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset_outputs", {21'd0, busy4, done4, e4, rs4, db4}, 0);
        late_done = 0;
        for (int c = 0; c < 2100; c++) begin
            if (done4) late_done++;
            @(negedge clk);
        end
        check("midreset_no_done", late_done, 0);
        run_transfer(vecs[1], "after_reset");

        // 8-bit back-to-back: start held in the done cycle is accepted at once.
        sel8    = 1'b1;
        nib     = 1'b0;
        data    = 10'h038;
        start_r = 1'b1;
        @(negedge clk);
        start_r   = 1'b0;
        late_done = -1;
        for (int c = 0; c < 20000; c++) begin
            if (done8) begin
                late_done = c;
                break;
            end
            @(negedge clk);
        end
        check("b2b_first_done", late_done, 2015);
        check("b2b_db_first", {24'd0, db8}, 32'h38);
        data    = 10'h241;
        start_r = 1'b1;
        @(negedge clk);
        start_r = 1'b0;
        check("b2b_second_accepted", {22'd0, busy8, e8, db8}, {22'd0, 1'b1, 1'b0, 8'h41});
        check("b2b_second_rs", {31'd0, rs8}, 1);
        late_done = -1;
        for (int c = 0; c < 20000; c++) begin
            if (done8) begin
                late_done = c;
                break;
            end
            @(negedge clk);
        end
        check("b2b_second_done", late_done, 2015);
        check("rw_always_low", {30'd0, rw4, rw8}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
